// File: rtl/dff_pipe_re.sv
// WIDTH-bit, DEPTH-stage enabled delay line with per-stage valid bits,
// synchronous clear and a registered occupancy counter.
module dff_pipe_re #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         clr,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic [WIDTH*DEPTH-1:0]       tap
);

    localparam int FW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] s [DEPTH];
    logic [DEPTH-1:0] v;

    // Invalid input slots are zero-gated to RESET_VAL so tap never depends on d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) s[i] <= RESET_VAL;
            v    <= '0;
            fill <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) s[i] <= RESET_VAL;
            v    <= '0;
            fill <= '0;
        end else if (enable) begin
            s[0] <= d_valid ? d : RESET_VAL;
            v[0] <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                s[i] <= s[i-1];
                v[i] <= v[i-1];
            end
            fill <= fill + FW'(d_valid) - FW'(v[DEPTH-1]);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign tap[WIDTH*g +: WIDTH] = s[g];
    end

    assign q       = s[DEPTH-1];
    assign q_valid = v[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe_re.sv
// Self-checking bench for dff_pipe_re: two instances (DEPTH=4/RESET_VAL=0 and
// DEPTH=1/RESET_VAL=5A) share stimulus; a queue-based model and scoreboard check them.
module tb_dff_pipe_re;

    typedef struct {
        logic       v;
        logic [7:0] s;
    } slot_t;

    localparam int         DP [2] = '{4, 1};
    localparam logic [7:0] RV [2] = '{8'h00, 8'h5A};

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       clr;
    logic [7:0] d;
    logic       d_valid;

    logic [7:0]  q_a, q_b;
    logic        qv_a, qv_b;
    logic [2:0]  fill_a;
    logic [0:0]  fill_b;
    logic [31:0] tap_a;
    logic [7:0]  tap_b;

    logic [7:0]  q_o    [2];
    logic        qv_o   [2];
    logic [31:0] fill_o [2];
    logic [31:0] tap_o  [2];

    slot_t      m   [2][$];
    logic [7:0] sbq [2][$];
    int         checks;
    int         passes;
    logic       en_edge;

    dff_pipe_re #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .d(d), .d_valid(d_valid),
        .q(q_a), .q_valid(qv_a), .fill(fill_a), .tap(tap_a)
    );

    dff_pipe_re #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .d(d), .d_valid(d_valid),
        .q(q_b), .q_valid(qv_b), .fill(fill_b), .tap(tap_b)
    );

    assign q_o[0]    = q_a;
    assign q_o[1]    = q_b;
    assign qv_o[0]   = qv_a;
    assign qv_o[1]   = qv_b;
    assign fill_o[0] = {29'd0, fill_a};
    assign fill_o[1] = {31'd0, fill_b};
    assign tap_o[0]  = tap_a;
    assign tap_o[1]  = {24'd0, tap_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic void model_reset(input int k);
        m[k].delete();
        for (int i = 0; i < DP[k]; i++) m[k].push_back('{v: 1'b0, s: RV[k]});
    endfunction

    // The model is an ordered list of slots: newest at the front, q at the back.
    task automatic compare_model(input int k);
        logic [31:0] etap;
        int          cnt;
        etap = '0;
        cnt  = 0;
        for (int i = 0; i < DP[k]; i++) begin
            etap = etap | (32'(m[k][i].s) << (8 * i));
            if (m[k][i].v) cnt++;
        end
        check($sformatf("model_q%0d", k),    32'(q_o[k]),  32'(m[k][DP[k]-1].s));
        check($sformatf("model_qv%0d", k),   32'(qv_o[k]), 32'(m[k][DP[k]-1].v));
        check($sformatf("model_fill%0d", k), fill_o[k],    32'(cnt));
        check($sformatf("model_tap%0d", k),  tap_o[k],     etap);
    endtask

    always begin
        @(posedge clk);
        en_edge = rst_n && !clr && enable;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clr) model_reset(k);
            else if (enable) begin
                m[k].push_front('{v: d_valid, s: (d_valid ? d : RV[k])});
                void'(m[k].pop_back());
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            compare_model(k);
            if (en_edge && qv_o[k]) begin
                if (sbq[k].size() == 0) check($sformatf("sb_unexpected%0d", k), 32'(q_o[k]), 32'hFFFF_FFFF);
                else check($sformatf("sb_data%0d", k), 32'(q_o[k]), 32'(sbq[k].pop_front()));
            end
        end
    end

    task automatic apply_stimulus(input logic en, input logic c, input logic dv, input logic [7:0] dd);
        @(negedge clk);
        enable  = en;
        clr     = c;
        d_valid = dv;
        d       = dd;
        if (rst_n && c) begin
            sbq[0].delete();
            sbq[1].delete();
        end else if (rst_n && en && dv) begin
            sbq[0].push_back(dd);
            sbq[1].push_back(dd);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        sbq[0].delete();
        sbq[1].delete();
        #1;
        compare_model(0);
        compare_model(1);
        check("async_tap_zero", tap_o[0], 32'h0);
        @(negedge clk);
        enable  = 1'b0;
        clr     = 1'b0;
        d_valid = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        checks = 0;
        passes = 0;
        model_reset(0);
        model_reset(1);
        rst_n = 1'b0; enable = 1'b0; clr = 1'b0; d = 8'h00; d_valid = 1'b0;

        // Reset held: inputs toggle but outputs must stay at reset values.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(i[0], 1'b0, ~i[0], 8'(8'h33 + i));
            wait_edge();
            check("rst_fill", fill_o[0], 32'h0);
            check("rst_tap", tap_o[0], 32'h0);
        end
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;

        // Latency: A5 on edge 1 reaches q after edge 4.
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'hA5);
        wait_edge();
        check("lat_qv_e1", 32'(qv_a), 32'h0);
        check("lat_fill_e1", fill_o[0], 32'h1);
        for (int e = 2; e <= 5; e++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
            wait_edge();
            if (e <= 3) check("lat_qv_early", 32'(qv_a), 32'h0);
            if (e == 4) begin
                check("lat_q_e4", 32'(q_a), 32'hA5);
                check("lat_qv_e4", 32'(qv_a), 32'h1);
                check("lat_fill_e4", fill_o[0], 32'h1);
            end
            if (e == 5) check("lat_fill_e5", fill_o[0], 32'h0);
        end

        // Stall: two disabled edges after edge 2 delay the output to edge 6.
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'hA5);
        wait_edge();
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h77);
        wait_edge();
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
            wait_edge();
            check("stall_tap", tap_o[0], 32'h0000A500);
            check("stall_fill", fill_o[0], 32'h1);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        wait_edge();
        check("stall_qv_e5", 32'(qv_a), 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        wait_edge();
        check("stall_q_e6", 32'(q_a), 32'hA5);
        check("stall_qv_e6", 32'(qv_a), 32'h1);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        wait_edge();

        // Full pipe and steady state with samples 1..6.
        for (int n = 1; n <= 6; n++) begin
            apply_stimulus(1'b1, 1'b0, 1'b1, 8'(n));
            wait_edge();
            if (n >= 4) begin
                check("full_fill", fill_o[0], 32'h4);
                check("full_q", 32'(q_a), 32'(n - 3));
            end
        end
        check("full_tap", tap_o[0], 32'h03040506);

        // Clear beats enable with a valid input.
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'hFF);
        wait_edge();
        check("clr_fill", fill_o[0], 32'h0);
        check("clr_qv", 32'(qv_a), 32'h0);
        check("clr_tap", tap_o[0], 32'h0);
        check("clr_tap_b", tap_o[1], 32'h5A);

        // Bubble pattern: q_valid reproduces it delayed by DEPTH.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b0, (i < 5) ? pat[i] : 1'b0, 8'(10 + i));
            wait_edge();
            if (i >= 3 && i < 8) check("bubble_qv_a", 32'(qv_a), 32'(pat[i-3]));
            if (i < 5) check("bubble_qv_b", 32'(qv_b), 32'(pat[i]));
        end

        // Random traffic with one asynchronous reset mid-stream.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) async_reset();
            apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                           $urandom_range(0, 4) < 3, 8'($urandom));
        end
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        wait_edge();
        check("sb_drained_a", 32'(sbq[0].size()), 32'h0);
        check("sb_drained_b", 32'(sbq[1].size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dff_pipe_re.md
# dff_pipe_re

Parametrised successor to the single-bit enabled D flip-flop. It is a WIDTH-bit, DEPTH-stage enabled delay line with per-stage valid tracking, a synchronous clear and a registered occupancy count. It is the pipeline-register primitive for datapaths driven by the split-simulation flow. Stimulus and response stay CSV-compatible: one row per clock edge, and all outputs are sampled after the edge.

## Interface
- WIDTH, 8: data width in bits; ≥1.
- DEPTH, 4: number of register stages; ≥1.
- RESET_VAL, {WIDTH{1'b0}}: data value loaded by reset, by clear and by an invalid input.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  advance the pipeline on this edge.
- clr  in  1  synchronous clear; takes priority over enable.
- d  in  WIDTH  input data.
- d_valid  in  1  d carries a real sample this cycle.
- q  out  WIDTH  data of the last stage, s[DEPTH-1].
- q_valid  out  1  valid bit of the last stage.
- fill  out  $clog2(DEPTH+1)  number of valid stages, range 0..DEPTH.
- tap  out  WIDTH*DEPTH  all stage data, flattened; s[i] sits at bits [WIDTH*i +: WIDTH].

## Operation
- State per stage i: data s[i] (WIDTH bits) and valid v[i] (1 bit). Plus the fill register.
- rst_n=0, asynchronous and effective immediately:
  - all s[i]=RESET_VAL, all v[i]=0, fill=0.
  - therefore q=RESET_VAL, q_valid=0, tap all RESET_VAL.
- Rising clk edge, rst_n=1, priority highest first:
  1. clr=1: all s[i]=RESET_VAL, all v[i]=0, fill=0. The values of enable, d and d_valid are ignored.
  2. enable=1 (and clr=0):
     - s[0] = d_valid ? d : RESET_VAL; v[0] = d_valid.
     - s[i] = s[i-1] and v[i] = v[i-1] for i = 1..DEPTH-1.
     - fill = fill + d_valid - v[DEPTH-1], computed with pre-edge values. The result never leaves 0..DEPTH.
  3. enable=0: every register holds. d and d_valid are ignored.
- DEPTH=1: a single stage. fill is 1 bit and equals v[0].
- Invalid input is zero-gated to RESET_VAL, so tap is deterministic regardless of d while d_valid=0.
- Outputs come directly from registers. There is no combinational path from any input to any output.
- fill is a registered counter, not a popcount. It must always equal the number of set v[i]; the bench checks this every cycle.
- No backpressure and no stall output. Data leaving the last stage is dropped.

## Timing
- Latency: a sample accepted on edge k (enable=1, d_valid=1) appears at q with q_valid=1 after DEPTH enabled edges, counting edge k itself. Edges with enable=0 stretch the latency and do not count.
- Throughput: one sample per enabled edge.
- Simultaneous d_valid=1 and v[DEPTH-1]=1 on an enabled edge: fill is unchanged (steady state).
- Full pipe, fill=DEPTH: an enabled edge with d_valid=1 keeps fill=DEPTH and drops the oldest sample.
- clr together with enable and d_valid=1: clr wins, and the input sample is lost.
- Reset asserted mid-stream: the clear is immediate and is not delayed to the next edge. On deassertion, the first edge at which rst_n=1 is sampled behaves as a normal edge. Deassertion is treated as synchronous to clk in the bench.

## Test plan
- Reset: hold rst_n=0, toggle d, d_valid and enable for 3 cycles -> q=0, q_valid=0, fill=0, tap=0. Then drive rst_n=0 asynchronously mid-stream, between edges -> all outputs drop to 0 before the next edge.
- Latency, WIDTH=8, DEPTH=4: enable=1, d_valid=1, d=8'hA5 on edge 1, then d_valid=0 -> q=8'hA5 and q_valid=1 after edge 4 only. fill goes 1,1,1,1 and then returns to 0 after edge 5.
- Stall: as the latency test, but with enable=0 for 2 cycles after edge 2 -> q=8'hA5 appears after edge 6. tap and fill are frozen during the stall.
- Full and steady state: 6 consecutive enabled valid samples 1..6 -> fill reaches 4 after edge 4 and stays 4. q shows 1,2,3 after edges 4,5,6. tap = {8'h03,8'h04,8'h05,8'h06} (bits [31:24] down to [7:0]) after edge 6.
- Clear priority: with the pipe full, drive clr=1, enable=1, d_valid=1, d=8'hFF -> after the edge fill=0, q_valid=0, tap=0. 8'hFF is not captured.
- Bubbles and parameter sweep: the pattern d_valid=1,0,1,1,0 with d=10..14 -> q_valid at the output reproduces 1,0,1,1,0 delayed by DEPTH; invalid slots read RESET_VAL; fill always equals the count of set v[i]. Repeat with DEPTH=1 and RESET_VAL=8'h5A.
